// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs instruction fields into 32-bit words and streams them
// with sequential byte addresses through a single registered valid/ready output stage.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_sel,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             out_illegal,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [6:0]  OP_R      = 7'h33;
    localparam logic [6:0]  OP_I      = 7'h13;
    localparam logic [6:0]  OP_LOAD   = 7'h03;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [6:0]  OP_JAL    = 7'h6F;
    localparam logic [6:0]  OP_JALR   = 7'h67;
    localparam logic [6:0]  OP_AUIPC  = 7'h17;
    localparam logic [6:0]  OP_LUI    = 7'h37;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        imm12_ok;
    logic        imm13_ok;
    logic        imm21_ok;
    logic        illegal;
    logic [31:0] word;
    logic [31:0] enc_instr;
    logic        accept;
    logic        handshake;

    // An immediate fits N signed bits when every bit from N-1 upward equals the sign bit.
    assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign imm13_ok = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign imm21_ok = (imm[31:20] == '0) || (imm[31:20] == '1);

    always_comb begin
        illegal = 1'b0;
        word    = NOP;
        case (op_sel)
            4'd0: begin
                illegal = !((func7 == 7'h00) ||
                            (func7 == 7'h20 && (func3 == 3'd0 || func3 == 3'd5)));
                word    = {func7, rs2, rs1, func3, rd, OP_R};
            end
            4'd1: begin
                if (func3 == 3'd1 || func3 == 3'd5) begin
                    illegal = (func3 == 3'd1) ? (func7 != 7'h00)
                                              : !(func7 == 7'h00 || func7 == 7'h20);
                    word    = {func7, imm[4:0], rs1, func3, rd, OP_I};
                end else begin
                    illegal = !imm12_ok;
                    word    = {imm[11:0], rs1, func3, rd, OP_I};
                end
            end
            4'd2: begin
                illegal = (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7) || !imm12_ok;
                word    = {imm[11:0], rs1, func3, rd, OP_LOAD};
            end
            4'd3: begin
                illegal = (func3 > 3'd2) || !imm12_ok;
                word    = {imm[11:5], rs2, rs1, func3, imm[4:0], OP_STORE};
            end
            4'd4: begin
                illegal = (func3 == 3'd2) || (func3 == 3'd3) || !imm13_ok || imm[0];
                word    = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OP_BRANCH};
            end
            4'd5: begin
                illegal = !imm21_ok || imm[0];
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            4'd6: begin
                illegal = !imm12_ok;
                word    = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            end
            4'd7:    word    = {imm[31:12], rd, OP_AUIPC};
            4'd8:    word    = {imm[31:12], rd, OP_LUI};
            default: illegal = 1'b1;
        endcase
        enc_instr = illegal ? NOP : word;
    end

    assign in_ready  = !restart && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // out_addr advances on every completed handshake, so it already points at the next
    // slot when a word is accepted; restart overrides any handshake in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_addr    <= BASE_ADDR;
            out_illegal <= 1'b0;
            err_cnt     <= '0;
        end else if (restart) begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            out_addr    <= BASE_ADDR;
        end else begin
            if (handshake) begin
                out_addr <= out_addr + 32'd4;
            end
            if (accept) begin
                out_valid   <= 1'b1;
                out_instr   <= enc_instr;
                out_illegal <= illegal;
                if (illegal && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised scoreboard bench for instr_encoder: a driver pushes reference-model results,
// an independent monitor compares them against each presented output word.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op_sel = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_illegal;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        ill;
        int          err;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] next_addr = BASE;
    int          err_model = 0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_word = '0;
    bit          fixed_ill = 1'b0;
    int          waits;

    instr_encoder #(.BASE_ADDR(BASE), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2),
        .func3(func3), .func7(func7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .out_illegal(out_illegal), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference encoder: legality from integer ranges, placement from the RV32I field maps.
    function automatic logic [32:0] ref_model(input logic [3:0] op, input logic [4:0] d,
                                              input logic [4:0] s1, input logic [4:0] s2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] im);
        int   v;
        bit   bad;
        bit   even;
        logic [31:0] w;
        v    = int'($signed(im));
        even = (v % 2) == 0;
        bad  = 1'b0;
        w    = 32'h0;
        case (op)
            4'd0: begin
                bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                w   = {f7, s2, s1, f3, d, 7'h33};
            end
            4'd1: begin
                if (f3 == 3'd1) begin
                    bad = f7 != 7'h00;
                    w   = {f7, im[4:0], s1, f3, d, 7'h13};
                end else if (f3 == 3'd5) begin
                    bad = !(f7 == 7'h00 || f7 == 7'h20);
                    w   = {f7, im[4:0], s1, f3, d, 7'h13};
                end else begin
                    bad = !(v >= -2048 && v <= 2047);
                    w   = {im[11:0], s1, f3, d, 7'h13};
                end
            end
            4'd2: begin
                bad = (f3 inside {3'd3, 3'd6, 3'd7}) || !(v >= -2048 && v <= 2047);
                w   = {im[11:0], s1, f3, d, 7'h03};
            end
            4'd3: begin
                bad = (f3 > 3'd2) || !(v >= -2048 && v <= 2047);
                w   = {im[11:5], s2, s1, f3, im[4:0], 7'h23};
            end
            4'd4: begin
                bad = (f3 inside {3'd2, 3'd3}) || !(v >= -4096 && v <= 4095) || !even;
                w   = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
            end
            4'd5: begin
                bad = !(v >= -1048576 && v <= 1048575) || !even;
                w   = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
            end
            4'd6: begin
                bad = !(v >= -2048 && v <= 2047);
                w   = {im[11:0], s1, 3'd0, d, 7'h67};
            end
            4'd7:    w   = {im[31:12], d, 7'h17};
            4'd8:    w   = {im[31:12], d, 7'h37};
            default: bad = 1'b1;
        endcase
        if (bad) w = 32'h0000_0013;
        return {bad, w};
    endfunction

    // Present one field set and wait (bounded) for it to be accepted; on acceptance the
    // expected word goes into the scoreboard.
    task automatic apply_stimulus(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] im, input bit rand_ready, output int nwait);
        logic [32:0] r;
        exp_t        e;
        bit          done;
        done = 1'b0;
        nwait = 0;
        op_sel = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
        in_valid = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk); #1;
            check_output("in_ready", 32'(in_ready),
                         32'(!restart && (sb.size() == 0 || out_ready)));
            if (in_ready) begin
                r = use_fixed ? {fixed_ill, fixed_word} : ref_model(op, d, s1, s2, f3, f7, im);
                if (r[32] && err_model < 255) err_model++;
                e.instr = r[31:0];
                e.addr  = next_addr;
                e.ill   = r[32];
                e.err   = err_model;
                sb.push_back(e);
                next_addr = next_addr + 32'd4;
                done = 1'b1;
            end else begin
                nwait++;
            end
            @(posedge clk); #1;
            if (!done && rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 60 cycles");
        end
    endtask

    task automatic apply_fixed(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] im, input logic [31:0] w, input bit ill,
                               output int nwait);
        use_fixed = 1'b1; fixed_word = w; fixed_ill = ill;
        apply_stimulus(op, d, s1, s2, f3, f7, im, 1'b0, nwait);
        use_fixed = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(posedge clk); #1;
        end
        check_output("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every presented word must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && !restart) begin
            if (sb.size() > 0) begin
                check_output("out_valid", 32'(out_valid), 32'd1);
                if (out_valid) begin
                    check_output("out_instr", out_instr, sb[0].instr);
                    check_output("out_addr", out_addr, sb[0].addr);
                    check_output("out_illegal", 32'(out_illegal), 32'(sb[0].ill));
                    check_output("err_cnt", 32'(err_cnt), 32'(sb[0].err));
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                check_output("out_valid_idle", 32'(out_valid), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] im;
        logic [6:0]  f7;
        int          s;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_instr", out_instr, 32'd0);
        check_output("rst_out_addr", out_addr, BASE);
        check_output("rst_out_illegal", 32'(out_illegal), 32'd0);
        check_output("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        $display("[TB] R-type");
        out_ready = 1'b1;
        apply_fixed(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0, waits);
        drain();

        $display("[TB] stream");
        next_addr = BASE + 32'd4;
        apply_fixed(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0, waits);
        check_output("stream_wait0", 32'(waits), 32'd0);
        apply_fixed(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 32'h0020A423, 1'b0, waits);
        check_output("stream_wait1", 32'(waits), 32'd0);
        apply_fixed(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8, 32'h00208463, 1'b0, waits);
        check_output("stream_wait2", 32'(waits), 32'd0);
        apply_fixed(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h123452B7, 1'b0, waits);
        check_output("stream_wait3", 32'(waits), 32'd0);
        drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        apply_stimulus(4'd0, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 32'd0, 1'b0, waits);
        fork
            apply_stimulus(4'd2, 5'd4, 5'd5, 5'd0, 3'd4, 7'h00, 32'hFFFF_F800, 1'b0, waits);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check_output("stall_waits", 32'(waits), 32'd3);
        drain();

        $display("[TB] illegal requests");
        apply_fixed(4'd3, 5'd0, 5'd1, 5'd2, 3'd3, 7'h00, 32'd0, 32'h00000013, 1'b1, waits);
        apply_fixed(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd7, 32'h00000013, 1'b1, waits);
        drain();
        check_output("err_cnt_two", 32'(err_cnt), 32'd2);

        $display("[TB] restart during stall");
        out_ready = 1'b0;
        apply_stimulus(4'd6, 5'd1, 5'd2, 5'd0, 3'd3, 7'h00, 32'd16, 1'b0, waits);
        op_sel = 4'd7; rd = 5'd9; imm = 32'hABCD_E000;
        in_valid = 1'b1;
        restart  = 1'b1;
        @(negedge clk); #1;
        check_output("restart_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        next_addr = BASE;
        @(posedge clk); #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        check_output("restart_out_valid", 32'(out_valid), 32'd0);
        check_output("restart_out_addr", out_addr, BASE);
        check_output("restart_out_illegal", 32'(out_illegal), 32'd0);
        out_ready = 1'b1;
        apply_stimulus(4'd7, 5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCD_E000, 1'b0, waits);
        drain();

        $display("[TB] random");
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0:       im = $urandom;
                1:       begin s = int'($urandom_range(0, 8191)) - 4096; im = 32'(s); end
                2:       begin s = (int'($urandom_range(0, 2097151)) - 1048576) & ~1; im = 32'(s); end
                default: im = 32'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            apply_stimulus(4'($urandom_range(0, 9)), 5'($urandom), 5'($urandom), 5'($urandom),
                           3'($urandom), f7, im, 1'b1, waits);
        end
        drain();

        $display("[TB] saturation");
        for (int n = 0; n < 300; n++) begin
            apply_stimulus(4'($urandom_range(9, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                           3'($urandom), 7'($urandom), $urandom, 1'b0, waits);
        end
        drain();
        check_output("err_cnt_sat", 32'(err_cnt), 32'h0000_00FF);

        $display("[TB] async reset mid-stall");
        out_ready = 1'b0;
        apply_stimulus(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 1'b0, waits);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_output("arst_out_valid", 32'(out_valid), 32'd0);
        check_output("arst_out_instr", out_instr, 32'd0);
        check_output("arst_out_addr", out_addr, BASE);
        check_output("arst_out_illegal", 32'(out_illegal), 32'd0);
        check_output("arst_err_cnt", 32'(err_cnt), 32'd0);
        sb.delete();
        next_addr = BASE;
        err_model = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        apply_stimulus(4'd1, 5'd2, 5'd3, 5'd0, 3'd5, 7'h20, 32'd7, 1'b0, waits);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
